// File: rtl/tank_bank.sv
// Per-frame position/facing update for a bank of player tanks, one tank per clock.
// Latency: tick cycle t -> tank i commits at end of t+1+i, frame_done high in t+NUM_TANKS+1.
// No backpressure: a vs rising edge outside IDLE is dropped; a pass always runs to completion.
//
// Ports:
//   Clk, Reset_n      clock and asynchronous active-low reset
//   vs                VGA vertical sync (rising edge = frame tick)
//   keycodes          USB report, KEY_SLOTS bytes, 0x00 = empty slot
//   tank_x / tank_y   top-left coordinates per tank, tank 0 in the LSBs
//   tank_dir          facing per tank: 0 up, 1 down, 2 left, 3 right
//   busy, frame_done  pass in progress / one-cycle pass-complete pulse
// Build option: define TANK_COLLIDE_EN to block moves that would overlap another tank.
module tank_bank #(
    parameter int NUM_TANKS = 2,
    parameter int COORD_W   = 10,
    parameter int KEY_SLOTS = 4,
    parameter int STEP      = 1,
    parameter int TANK_SIZE = 16,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int SPAWN_X0  = 64,
    parameter int SPAWN_DX  = 480,
    parameter int SPAWN_Y   = 232,
    // per tank {up,down,left,right}, tank 0 in the LSBs
    parameter logic [32*NUM_TANKS-1:0] KEYMAP = {32'h5251504F, 32'h1A160407}
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         vs,
    input  logic [8*KEY_SLOTS-1:0]       keycodes,
    output logic [NUM_TANKS*COORD_W-1:0] tank_x,
    output logic [NUM_TANKS*COORD_W-1:0] tank_y,
    output logic [2*NUM_TANKS-1:0]       tank_dir,
    output logic                         busy,
    output logic                         frame_done
);

    // Two guard bits so that the candidate can go negative or past the
    // top of the coordinate range without wrapping before the clamp.
    localparam int SW    = COORD_W + 2;
    localparam int IDX_W = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;

    localparam logic signed [SW-1:0] X_LO   = SW'(X_MIN);
    localparam logic signed [SW-1:0] X_HI   = SW'(X_MAX - TANK_SIZE + 1);
    localparam logic signed [SW-1:0] Y_LO   = SW'(Y_MIN);
    localparam logic signed [SW-1:0] Y_HI   = SW'(Y_MAX - TANK_SIZE + 1);
    localparam logic signed [SW-1:0] STEP_S = SW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic                   vs_prev;
    logic                   tick;
    logic                   last_tank;
    logic [8*KEY_SLOTS-1:0] snap;
    logic [IDX_W-1:0]       idx;

    logic [COORD_W-1:0]     pos_x [NUM_TANKS];
    logic [COORD_W-1:0]     pos_y [NUM_TANKS];
    logic [1:0]             dir   [NUM_TANKS];

    logic                   press_up, press_down, press_left, press_right;
    logic signed [SW-1:0]   cur_x, cur_y, dx, dy, cand_x, cand_y, new_x, new_y;
    logic [COORD_W-1:0]     commit_x, commit_y;
    logic [1:0]             new_dir;
    logic                   blocked;

    assign tick      = vs & ~vs_prev;
    assign last_tank = (idx == IDX_W'(NUM_TANKS - 1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (tick) state_nx = S_UPDATE;
            S_UPDATE: if (last_tank) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Move computation for tank idx
    // ------------------------------------------------------------------
    always_comb begin
        int km;
        km          = 32 * int'(idx);
        press_up    = 1'b0;
        press_down  = 1'b0;
        press_left  = 1'b0;
        press_right = 1'b0;
        for (int s = 0; s < KEY_SLOTS; s++) begin
            if (snap[8*s +: 8] == KEYMAP[km + 24 +: 8]) press_up    = 1'b1;
            if (snap[8*s +: 8] == KEYMAP[km + 16 +: 8]) press_down  = 1'b1;
            if (snap[8*s +: 8] == KEYMAP[km +  8 +: 8]) press_left  = 1'b1;
            if (snap[8*s +: 8] == KEYMAP[km      +: 8]) press_right = 1'b1;
        end

        // Opposite keys cancel on each axis.
        dy = '0;
        if (press_up && !press_down)      dy = -STEP_S;
        else if (press_down && !press_up) dy = STEP_S;
        dx = '0;
        if (press_left && !press_right)      dx = -STEP_S;
        else if (press_right && !press_left) dx = STEP_S;

        cur_x  = $signed({2'b00, pos_x[idx]});
        cur_y  = $signed({2'b00, pos_y[idx]});
        cand_x = cur_x + dx;
        cand_y = cur_y + dy;

        if (cand_x < X_LO)      new_x = X_LO;
        else if (cand_x > X_HI) new_x = X_HI;
        else                    new_x = cand_x;
        if (cand_y < Y_LO)      new_y = Y_LO;
        else if (cand_y > Y_HI) new_y = Y_HI;
        else                    new_y = cand_y;

        new_dir = dir[idx];
        if (press_up)         new_dir = 2'd0;
        else if (press_down)  new_dir = 2'd1;
        else if (press_left)  new_dir = 2'd2;
        else if (press_right) new_dir = 2'd3;

        blocked = 1'b0;
`ifdef TANK_COLLIDE_EN
        // Compare against committed positions: tanks earlier in this pass
        // have already moved, later ones still hold last frame's position.
        for (int j = 0; j < NUM_TANKS; j++) begin
            logic signed [SW-1:0] ddx, ddy;
            ddx = new_x - $signed({2'b00, pos_x[j]});
            ddy = new_y - $signed({2'b00, pos_y[j]});
            if (ddx < 0) ddx = -ddx;
            if (ddy < 0) ddy = -ddy;
            if (j != int'(idx) && ddx < SW'(TANK_SIZE) && ddy < SW'(TANK_SIZE))
                blocked = 1'b1;
        end
`endif

        // Clamped values are always inside the coordinate range.
        commit_x = blocked ? pos_x[idx] : COORD_W'(new_x);
        commit_y = blocked ? pos_y[idx] : COORD_W'(new_y);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_prev    <= 1'b0;
            snap       <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < NUM_TANKS; i++) begin
                pos_x[i] <= COORD_W'(SPAWN_X0 + i * SPAWN_DX);
                pos_y[i] <= COORD_W'(SPAWN_Y);
                dir[i]   <= 2'd0;
            end
        end else begin
            vs_prev    <= vs;
            busy       <= (state_nx == S_UPDATE);
            frame_done <= (state_nx == S_DONE);
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        snap <= keycodes;
                        idx  <= '0;
                    end
                end
                S_UPDATE: begin
                    pos_x[idx] <= commit_x;
                    pos_y[idx] <= commit_y;
                    dir[idx]   <= new_dir;
                    if (!last_tank) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tank_x   = '0;
        tank_y   = '0;
        tank_dir = '0;
        for (int i = 0; i < NUM_TANKS; i++) begin
            tank_x[i*COORD_W +: COORD_W] = pos_x[i];
            tank_y[i*COORD_W +: COORD_W] = pos_y[i];
            tank_dir[2*i +: 2]           = dir[i];
        end
    end

endmodule

// File: tb/tb_tank_bank.sv
module tb_tank_bank;
    localparam int NT = 2;
    localparam int CW = 10;
    localparam int XHI = 639 - 16 + 1;
    localparam int YHI = 479 - 16 + 1;

    logic                 Clk = 1'b0;
    logic                 Reset_n = 1'b0;
    logic                 vs = 1'b0;
    logic [31:0]          keycodes = '0;
    logic [NT*CW-1:0]     tank_x, tank_y;
    logic [2*NT-1:0]      tank_dir;
    logic                 busy, frame_done;

    int tests = 0;
    int fails = 0;

    // reference model state
    int mx [NT];
    int my [NT];
    int md [NT];
    byte unsigned km_up [NT] = '{8'h1A, 8'h52};
    byte unsigned km_dn [NT] = '{8'h16, 8'h51};
    byte unsigned km_lf [NT] = '{8'h04, 8'h50};
    byte unsigned km_rt [NT] = '{8'h07, 8'h4F};

    tank_bank dut (
        .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .keycodes(keycodes),
        .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 Clk = ~Clk;

    function automatic int dut_x(int i); return int'(tank_x[i*CW +: CW]); endfunction
    function automatic int dut_y(int i); return int'(tank_y[i*CW +: CW]); endfunction
    function automatic int dut_d(int i); return int'(tank_dir[2*i +: 2]); endfunction

    function automatic bit has_key(logic [31:0] k, byte unsigned c);
        for (int s = 0; s < 4; s++) if (k[8*s +: 8] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int iabs(int v); return (v < 0) ? -v : v; endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            mx[i] = 64 + i * 480;
            my[i] = 232;
            md[i] = 0;
        end
    endtask

    // One frame by the rules: tanks in order, each seeing the others' latest positions.
    task automatic model_frame(input logic [31:0] k);
        for (int i = 0; i < NT; i++) begin
            bit u, d, l, r, blk;
            int nx, ny;
            u = has_key(k, km_up[i]); d = has_key(k, km_dn[i]);
            l = has_key(k, km_lf[i]); r = has_key(k, km_rt[i]);
            nx = mx[i] + ((r && !l) ? 1 : (l && !r) ? -1 : 0);
            ny = my[i] + ((d && !u) ? 1 : (u && !d) ? -1 : 0);
            if (nx < 0) nx = 0;
            if (nx > XHI) nx = XHI;
            if (ny < 0) ny = 0;
            if (ny > YHI) ny = YHI;
            blk = 1'b0;
`ifdef TANK_COLLIDE_EN
            for (int j = 0; j < NT; j++)
                if (j != i && iabs(nx - mx[j]) < 16 && iabs(ny - my[j]) < 16) blk = 1'b1;
`endif
            if (!blk) begin mx[i] = nx; my[i] = ny; end
            if (u) md[i] = 0;
            else if (d) md[i] = 1;
            else if (l) md[i] = 2;
            else if (r) md[i] = 3;
        end
    endtask

    // Drives one vs rising edge with report k, scrambles keycodes after the tick,
    // raises a second vs edge mid-pass, and observes 10 cycles.
    task automatic run_frame(input logic [31:0] k, output int first_done,
                             output int n_done, output int busy_bad);
        first_done = -1; n_done = 0; busy_bad = 0;
        @(negedge Clk);
        keycodes = k;
        vs = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (frame_done === 1'b1) begin
                if (first_done < 0) first_done = c;
                n_done++;
            end
            if (busy !== ((c <= NT) ? 1'b1 : 1'b0)) busy_bad++;
            if (c == 1) begin keycodes = $urandom; vs = 1'b0; end
            if (c == 2) vs = 1'b1;
            if (c == 3) vs = 1'b0;
        end
        model_frame(k);
    endtask

    task automatic reset_dut();
        @(negedge Clk); Reset_n = 1'b0;
        @(negedge Clk); Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge Clk);
        for (int i = 0; i < NT; i++) begin
            tests++;
            if (dut_x(i) !== 64 + i * 480 || dut_y(i) !== 232 || dut_d(i) !== 0) begin
                fails++;
                $display("FAIL reset_pos tank%0d got (%0d,%0d,d%0d) want (%0d,232,d0)",
                         i, dut_x(i), dut_y(i), dut_d(i), 64 + i * 480);
            end
        end
        tests++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl busy=%b frame_done=%b want 0 0", busy, frame_done);
        end
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_move();
        int fd, nd, bb;
        run_frame(32'h0000_0007, fd, nd, bb);
        tests++;
        if (fd != NT + 1) begin fails++; $display("FAIL move_latency got %0d want %0d", fd, NT + 1); end
        tests++;
        if (nd != 1) begin fails++; $display("FAIL move_done_count got %0d want 1", nd); end
        tests++;
        if (bb != 0) begin fails++; $display("FAIL move_busy bad_cycles=%0d want 0", bb); end
        tests++;
        if (dut_x(0) !== 65 || dut_y(0) !== 232 || dut_d(0) !== 3) begin
            fails++;
            $display("FAIL move_tank0 got (%0d,%0d,d%0d) want (65,232,d3)", dut_x(0), dut_y(0), dut_d(0));
        end
        tests++;
        if (dut_x(1) !== 544 || dut_y(1) !== 232 || dut_d(1) !== 0) begin
            fails++;
            $display("FAIL move_tank1 got (%0d,%0d,d%0d) want (544,232,d0)", dut_x(1), dut_y(1), dut_d(1));
        end
    endtask

    task automatic test_clamp();
        int fd, nd, bb;
        for (int f = 0; f < 100; f++) begin
            run_frame((f < 70) ? 32'h0000_4F04 : 32'h0000_004F, fd, nd, bb);
            tests++;
            if (dut_x(0) !== mx[0] || dut_x(1) !== mx[1] || dut_x(0) == 1023) begin
                fails++;
                $display("FAIL clamp_frame%0d got x0=%0d x1=%0d want x0=%0d x1=%0d",
                         f, dut_x(0), dut_x(1), mx[0], mx[1]);
            end
        end
        tests++;
        if (dut_x(0) !== 0 || dut_x(1) !== 624) begin
            fails++;
            $display("FAIL clamp_final got x0=%0d x1=%0d want 0 624", dut_x(0), dut_x(1));
        end
    endtask

    task automatic test_opposite();
        int fd, nd, bb, y0;
        y0 = dut_y(0);
        run_frame(32'h0000_161A, fd, nd, bb);
        tests++;
        if (dut_y(0) !== y0 || dut_d(0) !== 0) begin
            fails++;
            $display("FAIL opposite got y=%0d d=%0d want y=%0d d=0", dut_y(0), dut_d(0), y0);
        end
    endtask

    task automatic test_random();
        byte unsigned pool [10] = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07,
                                    8'h52, 8'h51, 8'h50, 8'h4F, 8'h2C};
        int fd, nd, bb;
        for (int f = 0; f < 40; f++) begin
            logic [31:0] k;
            for (int s = 0; s < 4; s++) k[8*s +: 8] = pool[$urandom_range(9)];
            run_frame(k, fd, nd, bb);
            tests++;
            if (fd != NT + 1 || nd != 1 || bb != 0) begin
                fails++;
                $display("FAIL rand_timing frame%0d got done@%0d count=%0d busy_bad=%0d want done@%0d count=1 busy_bad=0",
                         f, fd, nd, bb, NT + 1);
            end
            for (int i = 0; i < NT; i++) begin
                tests++;
                if (dut_x(i) !== mx[i] || dut_y(i) !== my[i] || dut_d(i) !== md[i]) begin
                    fails++;
                    $display("FAIL rand_tank%0d frame%0d keys=%h got (%0d,%0d,d%0d) want (%0d,%0d,d%0d)",
                             i, f, k, dut_x(i), dut_y(i), dut_d(i), mx[i], my[i], md[i]);
                end
            end
        end
    endtask

    task automatic test_collision();
        int fd, nd, bb;
        reset_dut();
        for (int f = 0; f < 300; f++) begin
            run_frame(32'h0000_5007, fd, nd, bb);
            tests++;
            if (dut_x(0) !== mx[0] || dut_x(1) !== mx[1]) begin
                fails++;
                $display("FAIL collide_frame%0d got x0=%0d x1=%0d want x0=%0d x1=%0d",
                         f, dut_x(0), dut_x(1), mx[0], mx[1]);
            end
`ifdef TANK_COLLIDE_EN
            tests++;
            if (dut_x(1) - dut_x(0) < 16) begin
                fails++;
                $display("FAIL collide_gap frame%0d got gap=%0d want >=16", f, dut_x(1) - dut_x(0));
            end
`endif
        end
`ifndef TANK_COLLIDE_EN
        tests++;
        if (dut_x(0) <= dut_x(1)) begin
            fails++;
            $display("FAIL pass_through got x0=%0d x1=%0d want x0>x1", dut_x(0), dut_x(1));
        end
`endif
    endtask

    task automatic test_reset_mid_pass();
        int nd, fd, bb;
        nd = 0;
        @(negedge Clk);
        keycodes = 32'h0000_5104;
        vs = 1'b1;
        @(posedge Clk);            // tick cycle ends here
        #1 Reset_n = 1'b0;         // inside cycle t+1
        #1;
        for (int i = 0; i < NT; i++) begin
            tests++;
            if (dut_x(i) !== 64 + i * 480 || dut_y(i) !== 232 || dut_d(i) !== 0) begin
                fails++;
                $display("FAIL midreset_pos tank%0d got (%0d,%0d,d%0d) want (%0d,232,d0)",
                         i, dut_x(i), dut_y(i), dut_d(i), 64 + i * 480);
            end
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b want 0", busy); end
        @(negedge Clk); vs = 1'b0;
        @(negedge Clk); Reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (frame_done === 1'b1) nd++;
        end
        tests++;
        if (nd != 0) begin fails++; $display("FAIL midreset_no_done got %0d pulses want 0", nd); end
        run_frame(32'h0000_5104, fd, nd, bb);
        tests++;
        if (fd != NT + 1 || nd != 1) begin
            fails++;
            $display("FAIL midreset_next_pass got done@%0d count=%0d want done@%0d count=1", fd, nd, NT + 1);
        end
        for (int i = 0; i < NT; i++) begin
            tests++;
            if (dut_x(i) !== mx[i] || dut_y(i) !== my[i] || dut_d(i) !== md[i]) begin
                fails++;
                $display("FAIL midreset_tank%0d got (%0d,%0d,d%0d) want (%0d,%0d,d%0d)",
                         i, dut_x(i), dut_y(i), dut_d(i), mx[i], my[i], md[i]);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        test_reset();
        test_single_move();
        test_clamp();
        test_opposite();
        test_random();
        test_collision();
        test_reset_mid_pass();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
